gray_stream_source: RTL and testbench
=====================================

Name: gray_stream_source

Overview:
- Front-end stage that sits directly upstream of the Sobel edge filter.
- Accepts a camera RGB444 pixel stream and converts each pixel to 4-bit luma.
- Tracks raster position, checks frame framing, and drives the edge filter's pixel_in / in_ready inputs with a fixed-latency, no-backpressure stream.

Parameters:
IMG_W, 640, active pixels per line
IMG_H, 480, active lines per frame

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
rgb_in  input  12  pixel {R[11:8], G[7:4], B[3:0]}
in_valid  input  1  rgb_in valid this cycle
sof_in  input  1  marks rgb_in as first pixel of a frame; qualified by in_valid
pixel_out  output  4  grayscale pixel to edge filter
out_valid  output  1  pixel_out valid; connects to edge filter in_ready
sof_out  output  1  pixel_out is pixel (0,0)
eol_out  output  1  pixel_out is last pixel of a line (col IMG_W-1)
eof_out  output  1  pixel_out is last pixel of frame (IMG_W-1, IMG_H-1)
col_out  output  $clog2(IMG_W)  column of pixel_out
row_out  output  $clog2(IMG_H)  row of pixel_out
frame_err  output  1  one-cycle pulse, early sof detected
frames_done  output  16  count of completed frames, wraps at 65535->0

Behaviour:
- Reset (rst=0, async): all outputs 0; pipeline valid bits 0; col/row counters 0; state IDLE. Deassertion takes effect on the next clk edge.
- Reset mid-frame: the partial frame is discarded. After release, out_valid stays 0 until a new sof_in is accepted.

Conversion:
- Y = 5*R + 9*G + 2*B, unsigned, 8 bits (max 240).
- pixel_out = (Y + 8) >> 4, i.e. round-to-nearest. Result is never above 15, so no saturation is needed.

Pipeline:
- Stage 1 registers Y and input tags. Stage 2 registers pixel_out and all side outputs.
- Latency is exactly 2 cycles from an accepted input to out_valid.
- All tags (sof_out, eol_out, eof_out, col_out, row_out, frame_err) travel with the pixel and assert in the same cycle as its out_valid.
- No backpressure: one pixel per accepted cycle, gaps pass through as out_valid=0. Outputs other than out_valid hold their last value when out_valid=0.

State machine, applied only on cycles with in_valid=1:
- IDLE:
  - sof_in=0: pixel dropped, nothing emitted.
  - sof_in=1: pixel accepted at (0,0), next position is (1,0), go to ACTIVE.
- ACTIVE:
  - sof_in=0: pixel accepted at the current (col,row). col increments; at IMG_W-1, col wraps to 0 and row increments. eol tag is set when col=IMG_W-1.
  - Last pixel (IMG_W-1, IMG_H-1): eof tag set, counters go to (0,0), frames_done increments (aligned with eof_out), go to IDLE.
  - sof_in=1 at a position other than (0,0): early sof. The pixel is accepted as (0,0) of a new frame, frame_err pulses aligned with its sof_out, counters restart, state stays ACTIVE. frames_done does not increment.
  - sof_in=1 at (0,0) in ACTIVE cannot occur, because ACTIVE is never at (0,0).
- in_valid=0: state and counters hold. sof_in is ignored.

Width rules:
- Counters use $clog2 widths.
- col_out/row_out are zero-extended if IMG_W or IMG_H is a power of two.

Test Plan:
1. IMG_W=4, IMG_H=3. Reset, then 12 valid pixels with sof_in on the first, rgb_in=0xFFF -> out_valid from cycle 2 after the first input; pixel_out=15 for all 12; sof_out on the 1st output, eol_out on the 4th/8th/12th, eof_out on the 12th; frames_done=1.
2. Luma values: rgb_in 0xF00 -> 5, 0x0F0 -> 8, 0x00F -> 2, 0x000 -> 0, 0x888 -> 8 (Y=128, (128+8)>>4=8). Each appears exactly 2 cycles after input.
3. Valid pixels before any sof_in -> no out_valid. First sof_in pixel emerges with sof_out=1, col_out=0, row_out=0.
4. sof_in at position (2,1) mid-frame -> frame_err=1 with sof_out=1 and col_out=0/row_out=0 on that pixel; frames_done unchanged; the following frame completes normally.
5. in_valid toggling 1,0,0,1 within a line -> outputs gapped identically; col_out continues 0,1 without skipping.
6. rst driven low mid-frame, asynchronously between clock edges -> out_valid=0 and frames_done=0 immediately. After release, pixels without sof_in are dropped until sof_in arrives.

Source files
------------

// File: rtl/gray_stream_source.sv
// gray_stream_source: RGB444 camera stream to 4-bit luma with raster tagging.
// Tracks frame position, flags early start-of-frame, and emits a fixed
// two-cycle-latency stream for the downstream edge filter.
module gray_stream_source #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [11:0]                rgb_in,
   input  logic                       in_valid,
   input  logic                       sof_in,
   output logic [3:0]                 pixel_out,
   output logic                       out_valid,
   output logic                       sof_out,
   output logic                       eol_out,
   output logic                       eof_out,
   output logic [$clog2(IMG_W)-1:0]   col_out,
   output logic [$clog2(IMG_H)-1:0]   row_out,
   output logic                       frame_err,
   output logic [15:0]                frames_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   col_reg, col_next;
   logic [RW-1:0]   row_reg, row_next;

   logic            accept;
   logic [CW-1:0]   tag_col;
   logic [RW-1:0]   tag_row;
   logic            tag_sof, tag_eol, tag_eof, tag_err;
   logic [7:0]      y_comb;

   logic            s1_valid_reg;
   logic [7:0]      s1_y_reg;
   logic            s1_sof_reg, s1_eol_reg, s1_eof_reg, s1_err_reg;
   logic [CW-1:0]   s1_col_reg;
   logic [RW-1:0]   s1_row_reg;
   logic [7:0]      y_rounded;

   // Weighted luma; weights sum to 16 so the max (240) fits in 8 bits.
   assign y_comb = 8'd5 * {4'd0, rgb_in[11:8]}
                 + 8'd9 * {4'd0, rgb_in[7:4]}
                 + 8'd2 * {4'd0, rgb_in[3:0]};

   // Round to nearest before dropping four bits; 240+8 still fits in 8 bits.
   assign y_rounded = s1_y_reg + 8'd8;

   // Framing FSM: decide acceptance, tag the pixel, advance raster position.
   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      accept     = 1'b0;
      tag_col    = col_reg;
      tag_row    = row_reg;
      tag_sof    = 1'b0;
      tag_err    = 1'b0;
      tag_eol    = 1'b0;
      tag_eof    = 1'b0;
      if (in_valid) begin
         if (sof_in) begin
            // ACTIVE is never parked at (0,0), so any sof seen there is early.
            accept  = 1'b1;
            tag_col = '0;
            tag_row = '0;
            tag_sof = 1'b1;
            tag_err = (state_reg == ACTIVE);
         end else if (state_reg == ACTIVE) begin
            accept = 1'b1;
         end
         if (accept) begin
            tag_eol = (tag_col == COL_LAST);
            tag_eof = tag_eol && (tag_row == ROW_LAST);
            if (tag_eof) begin
               state_next = IDLE;
               col_next   = '0;
               row_next   = '0;
            end else if (tag_eol) begin
               state_next = ACTIVE;
               col_next   = '0;
               row_next   = tag_row + RW'(1);
            end else begin
               state_next = ACTIVE;
               col_next   = tag_col + CW'(1);
               row_next   = tag_row;
            end
         end
      end
   end

   // State and raster position registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   // Stage 1: capture raw luma and the position tags of accepted pixels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_y_reg     <= '0;
         s1_sof_reg   <= 1'b0;
         s1_eol_reg   <= 1'b0;
         s1_eof_reg   <= 1'b0;
         s1_err_reg   <= 1'b0;
         s1_col_reg   <= '0;
         s1_row_reg   <= '0;
      end else begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_y_reg   <= y_comb;
            s1_sof_reg <= tag_sof;
            s1_eol_reg <= tag_eol;
            s1_eof_reg <= tag_eof;
            s1_err_reg <= tag_err;
            s1_col_reg <= tag_col;
            s1_row_reg <= tag_row;
         end
      end
   end

   // Stage 2: drive outputs; side outputs hold across gaps, frame_err pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         pixel_out   <= '0;
         sof_out     <= 1'b0;
         eol_out     <= 1'b0;
         eof_out     <= 1'b0;
         col_out     <= '0;
         row_out     <= '0;
         frame_err   <= 1'b0;
         frames_done <= '0;
      end else begin
         out_valid <= s1_valid_reg;
         frame_err <= s1_valid_reg & s1_err_reg;
         if (s1_valid_reg) begin
            pixel_out <= y_rounded[7:4];
            sof_out   <= s1_sof_reg;
            eol_out   <= s1_eol_reg;
            eof_out   <= s1_eof_reg;
            col_out   <= s1_col_reg;
            row_out   <= s1_row_reg;
            if (s1_eof_reg)
               frames_done <= frames_done + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_gray_stream_source.sv
// Testbench for gray_stream_source with a 4x3 image: scoreboard of expected
// output beats keyed by the cycle they must appear in.
module tb_gray_stream_source;

   localparam int W = 4;
   localparam int H = 3;

   logic        clk;
   logic        rst;
   logic [11:0] rgb_in;
   logic        in_valid;
   logic        sof_in;
   logic [3:0]  pixel_out;
   logic        out_valid;
   logic        sof_out;
   logic        eol_out;
   logic        eof_out;
   logic [1:0]  col_out;
   logic [1:0]  row_out;
   logic        frame_err;
   logic [15:0] frames_done;

   gray_stream_source #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .in_valid(in_valid), .sof_in(sof_in),
      .pixel_out(pixel_out), .out_valid(out_valid), .sof_out(sof_out),
      .eol_out(eol_out), .eof_out(eof_out), .col_out(col_out), .row_out(row_out),
      .frame_err(frame_err), .frames_done(frames_done)
   );

   typedef struct {
      int          due;
      logic [3:0]  pix;
      logic        sof, eol, eof, err;
      logic [1:0]  col, row;
      logic [15:0] frames;
   } exp_t;

   exp_t q[$];
   int   tests_run = 0;
   int   fails = 0;
   int   cyc = 0;

   // reference model state
   int   m_state = 0;
   int   m_col = 0;
   int   m_row = 0;
   int   m_frames = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || pixel_out !== e.pix || sof_out !== e.sof ||
                eol_out !== e.eol || eof_out !== e.eof || col_out !== e.col ||
                row_out !== e.row || frame_err !== e.err || frames_done !== e.frames) begin
               fails++;
               $display("FAIL beat@%0d: got v=%b pix=%0d sof=%b eol=%b eof=%b col=%0d row=%0d err=%b fd=%0d, expected v=1 pix=%0d sof=%b eol=%b eof=%b col=%0d row=%0d err=%b fd=%0d",
                        cyc, out_valid, pixel_out, sof_out, eol_out, eof_out, col_out, row_out,
                        frame_err, frames_done, e.pix, e.sof, e.eol, e.eof, e.col, e.row, e.err, e.frames);
            end else begin
               $display("[TB] beat@%0d pix=%0d col=%0d row=%0d sof=%b eol=%b eof=%b err=%b fd=%0d",
                        cyc, pixel_out, col_out, row_out, sof_out, eol_out, eof_out, frame_err, frames_done);
            end
         end else begin
            tests_run++;
            if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
               fails++;
               $display("FAIL idle@%0d: got out_valid=%b frame_err=%b, expected 0/0", cyc, out_valid, frame_err);
            end
         end
      end
   end

   // One input cycle; predicts the beat that must appear two cycles later.
   task automatic drive(input bit v, input bit s, input logic [11:0] rgb, input int xpix);
      exp_t e;
      bit   acc;
      int   c, r, y;
      in_valid = v;
      sof_in   = s;
      rgb_in   = rgb;
      acc = 0;
      c = m_col;
      r = m_row;
      e.err = 1'b0;
      if (v) begin
         if (s) begin
            e.err = (m_state == 1);
            c = 0;
            r = 0;
            acc = 1;
         end else if (m_state == 1) begin
            acc = 1;
         end
      end
      if (acc) begin
         y = 5 * int'(rgb[11:8]) + 9 * int'(rgb[7:4]) + 2 * int'(rgb[3:0]);
         e.pix = (xpix >= 0) ? 4'(xpix) : 4'((y + 8) / 16);
         e.sof = s;
         e.col = 2'(c);
         e.row = 2'(r);
         e.eol = (c == W - 1);
         e.eof = e.eol && (r == H - 1);
         if (e.eof) begin
            m_frames = (m_frames + 1) % 65536;
            m_state = 0; m_col = 0; m_row = 0;
         end else if (e.eol) begin
            m_state = 1; m_col = 0; m_row = r + 1;
         end else begin
            m_state = 1; m_col = c + 1; m_row = r;
         end
         e.frames = 16'(m_frames);
         e.due = cyc + 2;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 10) begin
         drive(0, 0, 12'h000, -1);
         n++;
      end
      drive(0, 0, 12'h000, -1);
      tests_run++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d beats still pending, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; sof_in = 1'b0; rgb_in = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, pixel_out, sof_out, eol_out, eof_out, col_out, row_out, frame_err, frames_done} !== '0) begin
         fails++;
         $display("FAIL reset_state: got v=%b pix=%0d fd=%0d, expected all zero", out_valid, pixel_out, frames_done);
      end
      rst = 1'b1;
      $display("[TB] reset released");
   endtask

   task automatic test_frame();
      for (int i = 0; i < W * H; i++) drive(1, i == 0, 12'hFFF, -1);
      drain();
      tests_run++;
      if (frames_done !== 16'd1) begin
         fails++;
         $display("FAIL frame_count: got %0d, expected 1", frames_done);
      end
   endtask

   task automatic test_luma();
      logic [11:0] rgbs [5] = '{12'hF00, 12'h0F0, 12'h00F, 12'h000, 12'h888};
      int          pix  [5] = '{5, 8, 2, 0, 8};
      for (int i = 0; i < 5; i++) drive(1, i == 0, rgbs[i], pix[i]);
      for (int i = 5; i < W * H; i++) drive(1, 0, 12'(i * 37), -1);
      drain();
   endtask

   task automatic test_no_sof();
      for (int i = 0; i < 3; i++) drive(1, 0, 12'hABC, -1);
      drive(1, 1, 12'h123, -1);
   endtask

   task automatic test_early_sof();
      int fd_before;
      for (int i = 0; i < 5; i++) drive(1, 0, 12'(i * 211), -1);
      fd_before = m_frames;
      drive(1, 1, 12'h5A5, -1);
      for (int i = 1; i < W * H; i++) drive(1, 0, 12'(i * 97), -1);
      drain();
      tests_run++;
      if (frames_done !== 16'(fd_before + 1)) begin
         fails++;
         $display("FAIL early_sof_count: got %0d, expected %0d", frames_done, fd_before + 1);
      end
   endtask

   task automatic test_gaps();
      drive(1, 1, 12'h111, -1);
      drive(0, 1, 12'h222, -1);
      drive(0, 0, 12'h333, -1);
      drive(1, 0, 12'h444, -1);
      drive(0, 0, 12'h000, -1);
      drive(1, 0, 12'h555, -1);
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 12'h666, -1);
      drive(1, 0, 12'h777, -1);
      tests_run++;
      if (out_valid !== 1'b1 || frames_done === 16'd0) begin
         fails++;
         $display("FAIL pre_reset: got out_valid=%b fd=%0d, expected 1 and nonzero", out_valid, frames_done);
      end
      #2;
      rst = 1'b0;
      in_valid = 1'b0;
      q.delete();
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || frames_done !== 16'd0) begin
         fails++;
         $display("FAIL async_reset: got out_valid=%b fd=%0d, expected 0/0", out_valid, frames_done);
      end
      m_state = 0; m_col = 0; m_row = 0; m_frames = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      $display("[TB] reset released mid-run");
      for (int i = 0; i < 3; i++) drive(1, 0, 12'hFFF, -1);
      for (int i = 0; i < W * H; i++) drive(1, i == 0, 12'(i * 53), -1);
      drain();
      tests_run++;
      if (frames_done !== 16'd1) begin
         fails++;
         $display("FAIL post_reset_count: got %0d, expected 1", frames_done);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_luma();
      test_no_sof();
      test_early_sof();
      test_gaps();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
